// File: rtl/pipelined_addsub_signed.sv
// -----------------------------------------------------------------------------
// pipelined_addsub_signed
//
// Pipelined two's-complement adder/subtractor. The WIDTH-bit carry chain is cut
// into STAGES equal chunks of C = WIDTH/STAGES bits. One chunk is added per
// stage, using the carry registered by the previous stage. Operand bits are
// skewed so that each chunk meets its carry. Sum bits are deskewed so that the
// whole result leaves the output register aligned.
//
// Internal form: op_b = sub ? ~b : b, c0 = sub ? 1 : cin,
//                raw  = a + op_b + c0 (WIDTH+1 bits).
//
// Latency: a bundle accepted on edge n is presented after edge n+STAGES. The
// input capture register is followed by STAGES adder stages, and the last adder
// stage is the output register. A single global advance (adv) freezes every
// register, including the valid bits, while the output is stalled.
//
// Parameters:
//   WIDTH   operand/result width; must be >= 2.
//   STAGES  pipeline depth and number of carry chunks; WIDTH % STAGES == 0.
//
// Configuration macro:
//   ADDSUB_SAT_EN  defined: the sum is clamped on signed overflow.
//                  undefined: the sum wraps.
//                  cout and overflow always report the unsaturated result.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand bundle valid
//   in_ready   block accepts a bundle this cycle
//   a, b       signed operands
//   cin        carry-in; used only when sub=0
//   sub        0: a+b+cin, 1: a-b (cin ignored)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   sum        signed result (wrapped or saturated)
//   cout       carry out of the MSB of the internal addition (1 = no borrow)
//   overflow   signed overflow of the true result
// -----------------------------------------------------------------------------
module pipelined_addsub_signed #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int C = WIDTH / STAGES;

  // Per-stage state. Entry k feeds the adder for chunk k.
  // The operand skew registers are shifted right by one chunk per stage, so
  // the chunk to add always sits in bits [C-1:0]. The deskew register collects
  // finished chunks from the top down. After the last chunk, chunk 0 lands in
  // bits [C-1:0].
  logic [WIDTH-1:0]  a_skew   [STAGES];
  logic [WIDTH-1:0]  b_skew   [STAGES];
  logic [WIDTH-1:0]  s_deskew [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] valid_q;

  logic [C:0]        chunk [STAGES];
  logic              adv;
  logic [WIDTH-1:0]  raw_sum;
  logic [WIDTH-1:0]  sum_next;
  logic              a_msb;
  logic              b_msb;
  logic              r_msb;
  logic              ovf_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // One C-bit adder per stage. Bit C of each chunk is that stage's carry out.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, a_skew[k][C-1:0]} + {1'b0, b_skew[k][C-1:0]}
               + (C+1)'(carry_q[k]);
    end
  end

  // The last chunk completes the deskew. The operand sign bits reach the last
  // stage as the top bits of the final chunk.
  assign raw_sum  = (s_deskew[STAGES-1] >> C)
                  | (WIDTH'(chunk[STAGES-1][C-1:0]) << (WIDTH - C));
  assign a_msb    = a_skew[STAGES-1][C-1];
  assign b_msb    = b_skew[STAGES-1][C-1];
  assign r_msb    = chunk[STAGES-1][C-1];
  assign ovf_next = (a_msb == b_msb) && (r_msb != a_msb);

`ifdef ADDSUB_SAT_EN
  // The clamp direction follows the sign of a. Overflow is only possible when
  // both addends share that sign.
  always_comb begin
    sum_next = raw_sum;
    if (ovf_next) begin
      sum_next = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum_next = raw_sum;
`endif

  // NOTE: the skew/deskew arrays are reset explicitly. Reset leaves them
  // defined as zero, and no stale operand can leak into a later carry chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_skew[k]   <= '0;
        b_skew[k]   <= '0;
        s_deskew[k] <= '0;
      end
      carry_q   <= '0;
      valid_q   <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value on the same edge. That is what makes this a pipeline.
      a_skew[0]   <= a;
      b_skew[0]   <= sub ? ~b : b;
      s_deskew[0] <= '0;          // no chunk finished yet
      carry_q[0]  <= sub | cin;   // subtract forces the +1 of ~b
      valid_q[0]  <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        a_skew[k]   <= a_skew[k-1] >> C;
        b_skew[k]   <= b_skew[k-1] >> C;
        s_deskew[k] <= (s_deskew[k-1] >> C)
                     | (WIDTH'(chunk[k-1][C-1:0]) << (WIDTH - C));
        carry_q[k]  <= chunk[k-1][C];
        valid_q[k]  <= valid_q[k-1];
      end
      out_valid <= valid_q[STAGES-1];
      sum       <= sum_next;
      cout      <= chunk[STAGES-1][C];
      overflow  <= ovf_next;
    end
  end

endmodule
